// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM responder: read (0x03), write (0x02), status (0x05) over a byte memory with a host backdoor port.
// MISO updates SYNC_STAGES+1 clk after the sclk fall; host_rdata is registered (1 cycle); no backpressure.
module spi_sram_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 busy,
  output logic                 cmd_err,
  output logic                 wr_pulse,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ, S_WRITE, S_STATUS, S_IGNORE
  } state_t;

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync, r_cs_real;
  logic                   r_cs_d, r_sclk_d;
  state_t                 r_state, w_next;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift, r_tx_shift;
  logic [15:0]            r_addr;
  logic                   r_is_read;
  logic                   r_miso, r_cmd_err, r_wr_pulse;
  logic [7:0]             r_host_rdata;
  logic [7:0]             r_mem [DEPTH];

  logic       w_cs, w_sclk, w_mosi;
  logic       w_cs_fall, w_rise, w_fall;
  logic       w_shift_en, w_tx_en, w_byte_done, w_spi_we, w_cmd_bad;
  logic [7:0] w_byte_in, w_tx_load;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_rise      = ~w_cs & w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_cs & ~w_sclk & r_sclk_d;
  assign w_byte_in   = {r_rx_shift[6:0], w_mosi};
  assign w_byte_done = w_shift_en & w_rise & (r_bit_cnt == 3'd7);
  assign w_spi_we    = w_byte_done & (r_state == S_WRITE);
  assign w_cmd_bad   = w_byte_done & (r_state == S_CMD) &
                       (w_byte_in != 8'h02) & (w_byte_in != 8'h03) & (w_byte_in != 8'h05);
  assign w_tx_load   = (r_state == S_STATUS) ? 8'h40 : r_mem[r_addr[ADDR_BITS-1:0]];

  // r_cs_real marks which sync stages hold real pin samples, so the reset fill of the
  // chain never looks like a cs_n falling edge when the pin is already low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_real   <= '0;
      r_cs_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_real   <= {r_cs_real[SYNC_STAGES-2:0], 1'b1};
      r_cs_d      <= w_cs & r_cs_real[SYNC_STAGES-1];
      r_sclk_d    <= w_sclk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_cs_fall) w_next = S_CMD;
      S_CMD:
        if (w_byte_done) begin
          if (w_byte_in == 8'h03 || w_byte_in == 8'h02) w_next = S_ADDR_HI;
          else if (w_byte_in == 8'h05)                  w_next = S_STATUS;
          else                                          w_next = S_IGNORE;
        end
      S_ADDR_HI: if (w_byte_done) w_next = S_ADDR_LO;
      S_ADDR_LO: if (w_byte_done) w_next = r_is_read ? S_READ : S_WRITE;
      default:   ;
    endcase
    if (w_cs && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_tx_en    = 1'b0;
    case (r_state)
      S_CMD, S_ADDR_HI, S_ADDR_LO, S_WRITE: w_shift_en = 1'b1;
      S_READ, S_STATUS:                     w_tx_en    = 1'b1;
      default:                              ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_addr     <= 16'h0000;
      r_is_read  <= 1'b0;
      r_miso     <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_cmd_err  <= w_cmd_bad;
      r_wr_pulse <= w_spi_we;
      if (r_state == S_IDLE || w_cs) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_tx_shift <= 8'h00;
        r_miso     <= 1'b0;
      end else begin
        if (w_shift_en && w_rise) begin
          r_rx_shift <= w_byte_in;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        if (w_byte_done) begin
          case (r_state)
            S_CMD:     r_is_read    <= (w_byte_in == 8'h03);
            S_ADDR_HI: r_addr[15:8] <= w_byte_in;
            S_ADDR_LO: r_addr[7:0]  <= w_byte_in;
            S_WRITE:   r_addr       <= r_addr + 16'd1;
            default:   ;
          endcase
        end
        if (w_tx_en) begin
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd0) begin
              r_miso     <= w_tx_load[7];
              r_tx_shift <= {w_tx_load[6:0], 1'b0};
              if (r_state == S_READ) r_addr <= r_addr + 16'd1;
            end else begin
              r_miso     <= r_tx_shift[7];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
        end else begin
          r_miso <= 1'b0;
        end
      end
    end
  end

  // Memory is deliberately outside reset; SPI and host writes are exclusive via busy.
  always_ff @(posedge clk) begin
    if (w_spi_we)             r_mem[r_addr[ADDR_BITS-1:0]] <= w_byte_in;
    else if (host_we && w_cs) r_mem[host_addr]             <= host_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) r_host_rdata <= 8'h00;
    else       r_host_rdata <= r_mem[host_addr];
  end

  assign spi_miso   = r_miso;
  assign busy       = ~w_cs;
  assign cmd_err    = r_cmd_err;
  assign wr_pulse   = r_wr_pulse;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI master tasks, host port tasks and a byte scoreboard.
module tb_spi_sram_responder;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       reset, spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, busy, cmd_err, wr_pulse;
  logic       host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;

  int         total = 0;
  int         bad   = 0;
  int         wr_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];

  spi_sram_responder dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy), .cmd_err(cmd_err),
    .wr_pulse(wr_pulse), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_pulse === 1'b1) wr_cnt++;
    if (cmd_err === 1'b1)  err_cnt++;
  end

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s obs=%02h exp=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%02h exp=%02h", tag, obs, e);
      end
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      #HALF;
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #100;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  initial begin
    logic [7:0] rx;
    int         w0, e0;

    reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    repeat (4) @(negedge clk);
    checkn("rst_miso", int'(spi_miso), 0);
    checkn("rst_busy", int'(busy), 0);
    checkn("rst_cmd_err", int'(cmd_err), 0);
    checkn("rst_wr_pulse", int'(wr_pulse), 0);
    checkn("rst_host_rdata", int'(host_rdata), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Sequential read of preloaded bytes
    host_write(8'h10, 8'hA5);
    host_write(8'h11, 8'h5A);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    cs_low();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    spi_byte(8'h00, rx); sb_check("read_0x10", rx);
    spi_byte(8'h00, rx); sb_check("read_0x11", rx);
    cs_high();

    // Sequential write wrapping 0xFF -> 0x00
    w0 = wr_cnt;
    cs_low();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'hFE, rx);
    spi_byte(8'h11, rx); spi_byte(8'h22, rx); spi_byte(8'h33, rx);
    cs_high();
    checkn("write_wr_pulses", wr_cnt - w0, 3);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    host_read(8'hFE, rx); sb_check("mem_0xFE", rx);
    host_read(8'hFF, rx); sb_check("mem_0xFF", rx);
    host_read(8'h00, rx); sb_check("mem_0x00_wrap", rx);

    // Status repeats 0x40
    exp_q.push_back(8'h40); exp_q.push_back(8'h40);
    cs_low();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx); sb_check("status_0", rx);
    spi_byte(8'h00, rx); sb_check("status_1", rx);
    cs_high();

    // Unsupported command
    host_write(8'h9F, 8'h3C);
    e0 = err_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    cs_low();
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, rx); sb_check("ignore_miso_0", rx);
    spi_byte(8'hFF, rx); sb_check("ignore_miso_1", rx);
    cs_high();
    checkn("cmd_err_cycles", err_cnt - e0, 1);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hA5);
    host_read(8'h9F, rx); sb_check("ignore_mem_0x9F", rx);
    host_read(8'h10, rx); sb_check("ignore_mem_0x10", rx);

    // Partial write byte is discarded
    host_write(8'h20, 8'hC3);
    w0 = wr_cnt;
    cs_low();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    checkn("partial_wr_pulses", wr_cnt - w0, 0);
    exp_q.push_back(8'hC3);
    host_read(8'h20, rx); sb_check("partial_mem_0x20", rx);

    // Host write blocked while busy
    host_write(8'h30, 8'h00);
    @(negedge clk); spi_cs_n = 1'b0;
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    checkn("busy_high", int'(busy), 1);
    host_write(8'h30, 8'h77);
    spi_cs_n = 1'b1;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    checkn("busy_low", int'(busy), 0);
    exp_q.push_back(8'h00);
    host_read(8'h30, rx); sb_check("host_we_blocked", rx);
    host_write(8'h30, 8'h77);
    exp_q.push_back(8'h77);
    host_read(8'h30, rx); sb_check("host_we_idle", rx);

    // Reset mid-write with cs_n held low: needs a fresh cs_n fall afterwards
    host_write(8'h40, 8'h99);
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
    spi_bits(8'hF0, 4, rx);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkn("post_rst_busy", int'(busy), 1);
    checkn("post_rst_miso", int'(spi_miso), 0);
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx); spi_byte(8'hAA, rx);
    cs_high();
    checkn("post_rst_wr_pulses", wr_cnt - w0, 0);
    checkn("post_rst_cmd_err", err_cnt - e0, 0);
    exp_q.push_back(8'h99);
    host_read(8'h40, rx); sb_check("post_rst_mem_0x40", rx);
    exp_q.push_back(8'h99);
    cs_low();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
    spi_byte(8'h00, rx); sb_check("post_rst_spi_read", rx);
    cs_high();

    checkn("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
